// File: rtl/uart_stim_pkg.sv
// Shared types and constants for the UART stimulus transmitter.
package uart_stim_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5,
    MAB    = 3'd6
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

endpackage

// File: rtl/uart_stim_fifo.sv
// Synchronous TX FIFO; pointers carry an extra wrap bit so full and empty
// are told apart without a separate counter.
module uart_stim_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         push_ok, pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = LVL_W'(wr_ptr - rd_ptr);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Full is taken from the registered pointers only, so a push into a full
  // FIFO is dropped even when a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer update; reset flushes the queue by equalising the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_stim_tx.sv
// UART transmitter with input FIFO, runtime baud divisor, configurable
// parity / stop bits and line-break generation. Idle line is high.
module uart_stim_tx #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 send_break,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [LVL_W-1:0]     fifo_level
);

  import uart_stim_pkg::*;

  localparam logic [DIV_W-1:0] ONE      = 1;
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [3:0]       BRK_LAST = 4'(DATA_BITS + 2);

  state_t               state;
  logic [DIV_W-1:0]     cnt, div_q, div_in;
  logic [DATA_BITS-1:0] shift, fifo_data;
  logic [3:0]           bit_idx, brk_bits;
  logic                 par_en_q, par_bit_q, two_q, stop_left, break_pend;
  logic                 fifo_full, fifo_empty;
  logic                 bit_end, brk_req, stop_end, can_start;
  logic                 start_frame, start_break, enter_stop, done_next;

  uart_stim_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (start_frame),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign wr_ready = ~fifo_full;
  assign busy     = (state != IDLE) | (fifo_level != '0);

  // A zero divisor behaves as one clock per bit.
  assign div_in  = (baud_div == '0) ? ONE : baud_div;
  assign bit_end = (cnt == '0);

  // A break request is latched so a short pulse during a frame is honoured
  // once the frame's stop bits finish.
  assign brk_req = send_break | break_pend;

  // The end of the final stop bit makes the same decision as IDLE so that
  // queued frames follow back-to-back with no idle gap.
  assign stop_end    = (state == STOP) && bit_end && !stop_left;
  assign can_start   = (state == IDLE) || stop_end;
  assign start_break = can_start && brk_req;
  assign start_frame = can_start && !brk_req && !fifo_empty;

  // frame_done is registered, so it is raised on the edge that lands the
  // FSM in the last cycle of the final stop bit.
  assign enter_stop = ((state == DATA) && bit_end && (bit_idx == LAST_BIT) && !par_en_q) ||
                      ((state == PARITY) && bit_end);
  assign done_next  = (enter_stop && !two_q && (div_q == ONE)) ||
                      ((state == STOP) && !stop_left && (cnt == ONE)) ||
                      ((state == STOP) && stop_left && bit_end && (div_q == ONE));

  // Transmit FSM with bit timer, shift register and registered line output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      cnt        <= '0;
      div_q      <= ONE;
      shift      <= '0;
      bit_idx    <= '0;
      brk_bits   <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_q      <= 1'b0;
      stop_left  <= 1'b0;
      break_pend <= 1'b0;
    end else begin
      frame_done <= done_next;

      if (start_break)                        break_pend <= 1'b0;
      else if (send_break && state != BREAK)  break_pend <= 1'b1;

      if (state != IDLE && !bit_end) cnt <= cnt - ONE;

      if (start_break) begin
        state    <= BREAK;
        tx       <= 1'b0;
        div_q    <= div_in;
        cnt      <= div_in - ONE;
        brk_bits <= '0;
      end else if (start_frame) begin
        state     <= START;
        tx        <= 1'b0;
        div_q     <= div_in;
        cnt       <= div_in - ONE;
        shift     <= fifo_data;
        par_en_q  <= (parity_mode == PAR_ODD) || (parity_mode == PAR_EVEN);
        par_bit_q <= (parity_mode == PAR_EVEN) ? ^fifo_data : ~^fifo_data;
        two_q     <= two_stop;
      end else begin
        case (state)
          IDLE: tx <= 1'b1;
          START: if (bit_end) begin
            state   <= DATA;
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            cnt     <= div_q - ONE;
          end
          DATA: if (bit_end) begin
            cnt <= div_q - ONE;
            if (bit_idx == LAST_BIT) begin
              if (par_en_q) begin
                state <= PARITY;
                tx    <= par_bit_q;
              end else begin
                state     <= STOP;
                tx        <= 1'b1;
                stop_left <= two_q;
              end
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end
          PARITY: if (bit_end) begin
            state     <= STOP;
            tx        <= 1'b1;
            stop_left <= two_q;
            cnt       <= div_q - ONE;
          end
          STOP: if (bit_end) begin
            if (stop_left) begin
              stop_left <= 1'b0;
              cnt       <= div_q - ONE;
            end else begin
              state <= IDLE;
            end
          end
          BREAK: if (bit_end) begin
            cnt <= div_q - ONE;
            if (brk_bits == BRK_LAST && !send_break) begin
              state <= MAB;
              tx    <= 1'b1;
            end else if (brk_bits != BRK_LAST) begin
              brk_bits <= brk_bits + 4'd1;
            end
          end
          MAB: if (bit_end) state <= IDLE;
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed bench for uart_stim_tx: frame shapes, parity, stop bits, FIFO
// back-pressure, break generation and asynchronous reset.
module tb_uart_stim_tx;

  localparam int DATA_BITS  = 8;
  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_data = '0;
  logic [15:0]      baud_div = 16'd4;
  logic [1:0]       parity_mode = 2'd0;
  logic             two_stop = 1'b0;
  logic             send_break = 1'b0;
  logic             wr_ready, tx, busy, frame_done;
  logic [LVL_W-1:0] fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] frm;
  logic [5:0]  exp_rdy;

  always #5 clk = ~clk;

  uart_stim_tx #(
    .DATA_BITS  (DATA_BITS),
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LVL_W      (LVL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .send_break  (send_break),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done),
    .fifo_level  (fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds wr_valid across exactly one posedge.
  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Frame start must appear one cycle after the push becomes visible.
  task automatic wait_low(input string tag);
    int w;
    w = 0;
    while (tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_start_lat"}, w, 1);
  endtask

  // Checks tx and frame_done for frame cycles [from..to]; frm bit 0 is start.
  task automatic check_bits(input string tag, input logic [15:0] f, input int div,
                            input int nbits, input int from, input int to);
    for (int c = from; c <= to; c++) begin
      chk($sformatf("%s_tx%0d", tag, c), tx, f[c / div]);
      chk($sformatf("%s_fd%0d", tag, c), frame_done, (c == nbits * div - 1) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  task automatic expect_run(input string tag, input logic v, input int n);
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s_tx%0d", tag, c), tx, v);
      chk($sformatf("%s_fd%0d", tag, c), frame_done, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_level", fifo_level, 0);
    rst = 1'b0;
    @(negedge clk);

    // 8N1, div 4, 0x41
    baud_div = 16'd4;
    push(8'h41);
    wait_low("t1");
    frm = {6'd0, 1'b1, 8'h41, 1'b0};
    check_bits("t1", frm, 4, 10, 0, 39);
    chk("t1_busy_after", busy, 0);
    chk("t1_tx_after", tx, 1);

    // Even parity, two stops, div 2, 0x0D -> parity 1, 24 cycles
    parity_mode = 2'd2; two_stop = 1'b1; baud_div = 16'd2;
    push(8'h0D);
    wait_low("t2");
    frm = {4'd0, 2'b11, 1'b1, 8'h0D, 1'b0};
    check_bits("t2", frm, 2, 12, 0, 23);
    chk("t2_busy_after", busy, 0);

    // Odd parity, one stop, div 1, 0x0D -> parity 0
    parity_mode = 2'd1; two_stop = 1'b0; baud_div = 16'd1;
    push(8'h0D);
    wait_low("t3");
    frm = {5'd0, 1'b1, 1'b0, 8'h0D, 1'b0};
    check_bits("t3", frm, 1, 11, 0, 10);
    chk("t3_busy_after", busy, 0);

    // baud_div 0 behaves like 1; parity mode 3 means none
    parity_mode = 2'd3; baud_div = 16'd0;
    push(8'hFF);
    wait_low("t4a");
    frm = {6'd0, 1'b1, 8'hFF, 1'b0};
    check_bits("t4a", frm, 1, 10, 0, 9);
    chk("t4a_busy_after", busy, 0);
    parity_mode = 2'd0; baud_div = 16'd1;
    push(8'hFF);
    wait_low("t4b");
    check_bits("t4b", frm, 1, 10, 0, 9);

    // FIFO back-pressure: 6 pushes, 5 accepted, back-to-back frames
    baud_div = 16'd8;
    exp_rdy = 6'b011111;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t5_rdy%0d", i), wr_ready, exp_rdy[i]);
      push(8'((i + 1) * 17));
    end
    chk("t5_level_full", fifo_level, 4);
    frm = {6'd0, 1'b1, 8'h11, 1'b0};
    check_bits("t5_f0", frm, 8, 10, 4, 79);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("t5_level_f%0d", k), fifo_level, 4 - k);
      frm = {6'd0, 1'b1, 8'((k + 1) * 17), 1'b0};
      check_bits($sformatf("t5_f%0d", k), frm, 8, 10, 0, 79);
    end
    chk("t5_busy_after", busy, 0);
    chk("t5_level_after", fifo_level, 0);
    chk("t5_tx_after", tx, 1);

    // Break requested mid-frame for 2 bit times
    baud_div = 16'd4;
    push(8'hA5);
    wait_low("t6");
    frm = {6'd0, 1'b1, 8'hA5, 1'b0};
    check_bits("t6", frm, 4, 10, 0, 11);
    send_break = 1'b1;
    check_bits("t6", frm, 4, 10, 12, 19);
    send_break = 1'b0;
    check_bits("t6", frm, 4, 10, 20, 39);
    expect_run("t6_brk", 1'b0, 44);
    expect_run("t6_mab", 1'b1, 4);
    chk("t6_busy_after", busy, 0);
    expect_run("t6_idle", 1'b1, 8);

    // Async reset during DATA of 0x55 with 3 bytes queued
    push(8'h55);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    frm = {6'd0, 1'b1, 8'h55, 1'b0};
    check_bits("t7", frm, 4, 10, 2, 9);
    chk("t7_level_pre", fifo_level, 3);
    chk("t7_tx_pre", tx, 0);
    rst = 1'b1;
    #1;
    chk("t7_tx_rst", tx, 1);
    chk("t7_level_rst", fifo_level, 0);
    chk("t7_busy_rst", busy, 0);
    chk("t7_rdy_rst", wr_ready, 1);
    chk("t7_fd_rst", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_run("t7_post", 1'b1, 60);
    chk("t7_busy_post", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
